// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the multi-channel PE array.
// Holds the FSM state encoding, width helpers and the weight-index mapping.
// The optional PE_ARRAY_RELU_EN build macro is consumed by pe_array_mc.
package pe_array_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   function automatic int prod_width(input int dw, input int ww);
      return dw + ww;
   endfunction

   // Adding K*NCH products needs clog2(K*NCH) extra bits to stay exact.
   function automatic int sum_width(input int dw, input int ww, input int k, input int nch);
      return dw + ww + $clog2(k * nch);
   endfunction

   // Flat weight address: channel-major, then row, then column.
   function automatic int idx(input int ch, input int r, input int c, input int k);
      return (ch * k + r) * k + c;
   endfunction

endpackage

// File: rtl/pe_row_mac.sv
// One kernel row: KERNEL_SIZE multipliers, adder tree and channel accumulator.
// Latency: products registered on ld_i, accumulator updated one cycle later on acc_en_i.
// Backpressure: the caller freezes both stages by holding ld_i and acc_en_i low.
module pe_row_mac
   import pe_array_pkg::*;
#(
   parameter int KERNEL_SIZE  = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int SUM_WIDTH    = 18,
   parameter int SIGNED       = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 ld_i,
   input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]    pix_i,
   input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]  wgt_i,
   input  logic                                 acc_en_i,
   input  logic                                 clr_i,
   output logic [SUM_WIDTH-1:0]                 acc_d_o
);

   localparam int   PW  = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
   localparam int   EXT = SUM_WIDTH - PW;
   localparam logic SGN = (SIGNED != 0);

   logic [PW-1:0]        prod_d [KERNEL_SIZE];
   logic [PW-1:0]        prod_q [KERNEL_SIZE];
   logic [SUM_WIDTH-1:0] tree_sum;
   logic [SUM_WIDTH-1:0] acc_q;

   // Operands are extended to the full product width first, so the low PW bits
   // of the product are exact for both signed and unsigned operands.
   for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_mul
      logic [DATA_WIDTH-1:0]   px;
      logic [WEIGHT_WIDTH-1:0] wt;
      assign px        = pix_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign wt        = wgt_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign prod_d[k] = {{WEIGHT_WIDTH{SGN & px[DATA_WIDTH-1]}}, px}
                       * {{DATA_WIDTH{SGN & wt[WEIGHT_WIDTH-1]}}, wt};
   end

   // Row adder tree plus accumulate; a channel-0 beat overwrites the accumulator.
   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
         tree_sum = tree_sum + {{EXT{SGN & prod_q[k][PW-1]}}, prod_q[k]};
      end
      acc_d_o = (clr_i ? '0 : acc_q) + tree_sum;
   end

   // Stage-1 product registers and stage-2 accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < KERNEL_SIZE; k++) prod_q[k] <= '0;
         acc_q <= '0;
      end else begin
         if (ld_i) begin
            for (int k = 0; k < KERNEL_SIZE; k++) prod_q[k] <= prod_d[k];
         end
         if (acc_en_i) acc_q <= acc_d_o;
      end
   end

endmodule

// File: rtl/pe_array_mc.sv
// KxK PE array with serial weight load, per-row dot products accumulated over NUM_CH channels.
// Latency: out_valid rises 2 cycles after the last-channel beat is accepted; 1 beat/cycle.
// Backpressure: out_valid && !out_ready freezes both stages and drops in_ready. Macro: PE_ARRAY_RELU_EN.
module pe_array_mc
   import pe_array_pkg::*;
#(
   parameter int  KERNEL_SIZE   = 3,
   parameter int  NUM_CH        = 2,
   parameter int  DATA_WIDTH    = 8,
   parameter int  WEIGHT_WIDTH  = 8,
   parameter int  SIGNED        = 0,
   localparam int SUM_WIDTH     = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE, NUM_CH),
   localparam int TOTAL_WEIGHTS = KERNEL_SIZE * KERNEL_SIZE * NUM_CH,
   localparam int CW            = $clog2(NUM_CH) + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              w_start,
   input  logic                              w_valid,
   input  logic [WEIGHT_WIDTH-1:0]           w_data,
   output logic                              ready,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] dataIn,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SUM_WIDTH*KERNEL_SIZE-1:0]  dataOut,
   output logic [CW-1:0]                     ch_idx
);

   localparam int AW = $clog2(TOTAL_WEIGHTS);

   state_e                              state_q, state_d;
   logic [AW-1:0]                       waddr_q;
   logic [WEIGHT_WIDTH-1:0]             wgt_q [TOTAL_WEIGHTS];
   logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] wrow  [KERNEL_SIZE];
   logic [SUM_WIDTH-1:0]                row_sum [KERNEL_SIZE];
   logic [SUM_WIDTH*KERNEL_SIZE-1:0]    dout_d, dout_q;
   logic [CW-1:0]                       ch_q;
   logic                                s1_vld_q, s1_ch0_q, s1_last_q, out_vld_q;
   logic                                stall, accept, adv2, pipe_empty, restart;

   assign stall      = out_vld_q && !out_ready;
   assign in_ready   = (state_q == RUN) && !stall;
   assign accept     = in_valid && in_ready;
   assign adv2       = s1_vld_q && !stall;
   assign pipe_empty = !s1_vld_q && !out_vld_q;
   assign restart    = w_start && (state_d == LOAD);

   // Next-state logic; a reload from RUN waits for an empty pipeline.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_start) state_d = LOAD;
         LOAD:    if (!w_start && w_valid && waddr_q == AW'(TOTAL_WEIGHTS - 1)) state_d = RUN;
         RUN:     if (w_start && pipe_empty) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Serial weight store; any accepted w_start rewinds the address counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr_q <= '0;
         for (int i = 0; i < TOTAL_WEIGHTS; i++) wgt_q[i] <= '0;
      end else if (restart) begin
         waddr_q <= '0;
      end else if (state_q == LOAD && w_valid) begin
         wgt_q[waddr_q] <= w_data;
         waddr_q        <= waddr_q + 1'b1;
      end
   end

   // Pick each row's weights for the channel of the beat being accepted.
   always_comb begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         wrow[r] = '0;
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            wrow[r][c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wgt_q[AW'(idx(int'(ch_q), r, c, KERNEL_SIZE))];
         end
      end
   end

   for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
      pe_row_mac #(
         .KERNEL_SIZE (KERNEL_SIZE),
         .DATA_WIDTH  (DATA_WIDTH),
         .WEIGHT_WIDTH(WEIGHT_WIDTH),
         .SUM_WIDTH   (SUM_WIDTH),
         .SIGNED      (SIGNED)
      ) u_row (
         .clk     (clk),
         .rst     (rst),
         .ld_i    (accept),
         .pix_i   (dataIn),
         .wgt_i   (wrow[r]),
         .acc_en_i(adv2),
         .clr_i   (s1_ch0_q),
         .acc_d_o (row_sum[r])
      );
   end

   // Output word, optionally clamping negative sums to zero.
   always_comb begin
      dout_d = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         dout_d[r*SUM_WIDTH +: SUM_WIDTH] = row_sum[r];
`ifdef PE_ARRAY_RELU_EN
         if (SIGNED != 0 && row_sum[r][SUM_WIDTH-1]) dout_d[r*SUM_WIDTH +: SUM_WIDTH] = '0;
`endif
      end
   end

   // Channel counter and stage-1 beat tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q      <= '0;
         s1_vld_q  <= 1'b0;
         s1_ch0_q  <= 1'b0;
         s1_last_q <= 1'b0;
      end else begin
         if (!stall) s1_vld_q <= accept;
         if (accept) begin
            ch_q      <= (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
            s1_ch0_q  <= (ch_q == '0);
            s1_last_q <= (ch_q == CW'(NUM_CH - 1));
         end
      end
   end

   // Output register, loaded when the last channel leaves stage 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         dout_q    <= '0;
      end else if (!stall) begin
         out_vld_q <= adv2 && s1_last_q;
         if (adv2 && s1_last_q) dout_q <= dout_d;
      end
   end

   assign ready     = (state_q == RUN);
   assign out_valid = out_vld_q;
   assign dataOut   = dout_q;
   assign ch_idx    = ch_q;

endmodule

// File: tb/tb_pe_array_mc.sv
// Bench for pe_array_mc: instance A is NUM_CH=1 signed, instance B is NUM_CH=2 unsigned.
// Expected row sums come from a plain-arithmetic model fed at each accepted beat.
// Directed steps first, then random data, weights, gaps and backpressure.
module tb_pe_array_mc;

   localparam int K   = 3;
   localparam int SWA = 18;
   localparam int SWB = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst [2];
   logic            w_start [2], w_valid [2], in_valid [2], out_ready [2];
   logic [7:0]      w_data [2];
   logic [23:0]     din [2];
   logic            ready [2], in_ready [2], out_valid [2];
   logic [SWA*K-1:0] dout_a;
   logic [SWB*K-1:0] dout_b;
   logic [0:0]      chx_a;
   logic [1:0]      chx_b;

   pe_array_mc #(.KERNEL_SIZE(3), .NUM_CH(1), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SIGNED(1)) dut_a (
      .clk(clk), .rst(rst[0]), .w_start(w_start[0]), .w_valid(w_valid[0]), .w_data(w_data[0]),
      .ready(ready[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .dataIn(din[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dataOut(dout_a), .ch_idx(chx_a));

   pe_array_mc #(.KERNEL_SIZE(3), .NUM_CH(2), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SIGNED(0)) dut_b (
      .clk(clk), .rst(rst[1]), .w_start(w_start[1]), .w_valid(w_valid[1]), .w_data(w_data[1]),
      .ready(ready[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .dataIn(din[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dataOut(dout_b), .ch_idx(chx_b));

   int          n_pass = 0;
   int          n_total = 0;
   int          bp_mode [2] = '{0, 0};   // 0: always ready, 1: random, 2: held low
   int          wmod [2][18];
   int          grp [2][2][3];
   int          mch [2] = '{0, 0};
   logic [63:0] expq0 [$];
   logic [63:0] expq1 [$];
   logic [63:0] ea, eb, held;
   int          w, t;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int sx(input int v, input bit sgn);
      return (sgn && v > 127) ? v - 256 : v;
   endfunction

   // Reference: row r = sum over channels and columns of weight * pixel, kept to SUM_WIDTH bits.
   function automatic logic [63:0] model_out(input int d);
      logic [63:0] v;
      longint      s;
      int          sw, nc;
      v  = '0;
      sw = (d == 0) ? SWA : SWB;
      nc = (d == 0) ? 1 : 2;
      for (int r = 0; r < K; r++) begin
         s = 0;
         for (int ch = 0; ch < nc; ch++)
            for (int c = 0; c < K; c++)
               s += longint'(sx(wmod[d][(ch*K + r)*K + c], d == 0)) * longint'(sx(grp[d][ch][c], d == 0));
`ifdef PE_ARRAY_RELU_EN
         if (d == 0 && s < 0) s = 0;
`endif
         v = v | ((64'(s) & ((64'd1 << sw) - 64'd1)) << (r * sw));
      end
      return v;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat until accepted; the model records it on acceptance.
   task automatic send(input int d, input logic [23:0] pix, output int waits);
      int nc;
      nc = (d == 0) ? 1 : 2;
      waits = 0;
      in_valid[d] = 1'b1;
      din[d] = pix;
      @(negedge clk);
      while (!in_ready[d] && waits < 500) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready[d]) begin
         check("accept_timeout", 64'(in_ready[d]), 64'd1);
         in_valid[d] = 1'b0;
         return;
      end
      check(d == 0 ? "ch_idx_a" : "ch_idx_b", d == 0 ? 64'(chx_a) : 64'(chx_b), 64'(mch[d]));
      for (int k = 0; k < K; k++) grp[d][mch[d]][k] = int'(pix[k*8 +: 8]);
      if (mch[d] == nc - 1) begin
         if (d == 0) expq0.push_back(model_out(0));
         else        expq1.push_back(model_out(1));
         mch[d] = 0;
      end else begin
         mch[d]++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int d);
      int n;
      n = (d == 0) ? 9 : 18;
      w_start[d] = 1'b1;
      cycles(1);
      w_start[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
         w_valid[d] = 1'b1;
         w_data[d]  = 8'(wmod[d][i]);
         if (i == n - 1) check("ready_in_load", 64'(ready[d]), 64'd0);
         cycles(1);
      end
      w_valid[d] = 1'b0;
      check("ready_after_load", 64'(ready[d]), 64'd1);
   endtask

   // Scoreboard: every consumed output must match the oldest expected group.
   always @(negedge clk) begin
      if (!rst[0] && out_valid[0] && out_ready[0]) begin
         if (expq0.size() == 0) check("a_spurious_out", 64'(out_valid[0]), 64'd0);
         else begin
            ea = expq0.pop_front();
            check("a_dataOut", 64'(dout_a), ea);
         end
      end
      if (!rst[1] && out_valid[1] && out_ready[1]) begin
         if (expq1.size() == 0) check("b_spurious_out", 64'(out_valid[1]), 64'd0);
         else begin
            eb = expq1.pop_front();
            check("b_dataOut", 64'(dout_b), eb);
         end
      end
   end

   // Downstream ready generator.
   initial begin
      out_ready[0] = 1'b1;
      out_ready[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++)
            out_ready[d] = (bp_mode[d] == 0) ? 1'b1 :
                           (bp_mode[d] == 2) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; w_start[d] = 1'b0; w_valid[d] = 1'b0; w_data[d] = '0;
         in_valid[d] = 1'b0; din[d] = '0;
      end
      cycles(3);
      check("rst_ready_a", 64'(ready[0]), 64'd0);
      check("rst_inrdy_a", 64'(in_ready[0]), 64'd0);
      check("rst_ovld_a", 64'(out_valid[0]), 64'd0);
      check("rst_dout_a", 64'(dout_a), 64'd0);
      check("rst_ch_a", 64'(chx_a), 64'd0);
      check("rst_ready_b", 64'(ready[1]), 64'd0);
      check("rst_inrdy_b", 64'(in_ready[1]), 64'd0);
      check("rst_ovld_b", 64'(out_valid[1]), 64'd0);
      check("rst_dout_b", 64'(dout_b), 64'd0);
      check("rst_ch_b", 64'(chx_b), 64'd0);
      rst[0] = 1'b0; rst[1] = 1'b0;
      cycles(2);

      // A: row r weights = r+1, data [i,i+1,i+2].
      for (int i = 0; i < 9; i++) wmod[0][i] = i / 3 + 1;
      load(0);
      send(0, {8'd2, 8'd1, 8'd0}, w);
      in_valid[0] = 1'b0;
      @(negedge clk);
      check("latency_cycle1", 64'(out_valid[0]), 64'd0);
      @(negedge clk);
      check("latency_cycle2", 64'(out_valid[0]), 64'd1);
      check("i0_row2", 64'(dout_a[2*SWA +: SWA]), 64'd9);
      cycles(1);
      for (int i = 1; i < 5; i++) begin
         send(0, {8'(i + 2), 8'(i + 1), 8'(i)}, w);
         check("b2b_no_wait", 64'(w), 64'd0);
      end
      in_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("i4_row0", 64'(dout_a[0 +: SWA]), 64'd15);
      check("i4_row2", 64'(dout_a[2*SWA +: SWA]), 64'd45);
      cycles(2);

      // A: w_start with a beat in flight is ignored; after drain it reloads.
      send(0, {8'd3, 8'd3, 8'd3}, w);
      in_valid[0] = 1'b0;
      w_start[0] = 1'b1;
      cycles(1);
      w_start[0] = 1'b0;
      check("wstart_ignored", 64'(ready[0]), 64'd1);
      cycles(3);
      check("drained_a", 64'(out_valid[0]), 64'd0);
      w_start[0] = 1'b1;
      cycles(1);
      w_start[0] = 1'b0;
      check("wstart_to_load", 64'(ready[0]), 64'd0);

      // A: signed, weights -1, data [5,5,5].
      for (int i = 0; i < 9; i++) wmod[0][i] = 255;
      load(0);
      send(0, {8'd5, 8'd5, 8'd5}, w);
      in_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
`ifdef PE_ARRAY_RELU_EN
      check("signed_row0", 64'(dout_a[0 +: SWA]), 64'd0);
`else
      check("signed_row0", 64'(dout_a[0 +: SWA]), 64'h3FFF1);
`endif
      cycles(2);

      // B: ch0 weights 1, ch1 weights 2.
      for (int i = 0; i < 18; i++) wmod[1][i] = (i < 9) ? 1 : 2;
      load(1);
      send(1, {8'd3, 8'd2, 8'd1}, w);
      send(1, {8'd1, 8'd1, 8'd1}, w);
      in_valid[1] = 1'b0;
      check("ch_wrap", 64'(chx_b), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("two_ch_row0", 64'(dout_b[0 +: SWB]), 64'd12);
      cycles(2);

      // B: hold out_ready low while a result is pending.
      bp_mode[1] = 2;
      cycles(2);
      send(1, {8'd3, 8'd2, 8'd1}, w);
      send(1, {8'd1, 8'd1, 8'd1}, w);
      in_valid[1] = 1'b0;
      cycles(2);
      check("bp_pending", 64'(out_valid[1]), 64'd1);
      held = 64'(dout_b);
      for (int i = 0; i < 4; i++) begin
         in_valid[1] = 1'b1;
         din[1] = {8'd4, 8'd4, 8'd4};
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready[1]), 64'd0);
         check("bp_dout_stable", 64'(dout_b), held);
         cycles(1);
      end
      bp_mode[1] = 0;
      send(1, {8'd4, 8'd4, 8'd4}, w);
      send(1, {8'd1, 8'd1, 8'd1}, w);
      in_valid[1] = 1'b0;
      cycles(6);

      // B: reset in the middle of a weight load.
      w_start[1] = 1'b1;
      cycles(1);
      w_start[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_valid[1] = 1'b1;
         w_data[1] = 8'(i);
         cycles(1);
      end
      w_valid[1] = 1'b0;
      rst[1] = 1'b1;
      @(negedge clk);
      check("midload_rst_ready", 64'(ready[1]), 64'd0);
      check("midload_rst_ch", 64'(chx_b), 64'd0);
      check("midload_rst_ovld", 64'(out_valid[1]), 64'd0);
      cycles(1);
      rst[1] = 1'b0;
      mch[1] = 0;
      cycles(1);

      // Random weights, data, input gaps and output backpressure on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 18; i++) wmod[d][i] = int'($urandom_range(0, 255));
         load(d);
      end
      bp_mode[0] = 1;
      bp_mode[1] = 1;
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 40; b++) begin
            send(d, 24'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
               in_valid[d] = 1'b0;
               cycles(int'($urandom_range(1, 3)));
            end
         end
         in_valid[d] = 1'b0;
      end
      bp_mode[0] = 0;
      bp_mode[1] = 0;
      t = 0;
      while ((expq0.size() != 0 || expq1.size() != 0) && t < 200) begin
         cycles(1);
         t++;
      end
      check("drain_a", 64'(expq0.size()), 64'd0);
      check("drain_b", 64'(expq1.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
